cache_assoc_ctrl: RTL



---
 rtl/cache_assoc_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_assoc_ctrl.sv
// N-way set-associative write-back / write-allocate cache controller.
// Ports: clk/rst; cpu_* request port; mem_* block bus; hit_cnt/miss_cnt.
module cache_assoc_ctrl #(
  parameter int OFFSET_WIDTH = 3,
  parameter int INDEX_WIDTH  = 7,
  parameter int WAYS         = 2,
  parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
  parameter int BLOCK_BITS   = 32 << OFFSET_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [3:0]            cpu_byte_en,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [BLOCK_BITS-1:0] mem_wdata,
  input  logic [BLOCK_BITS-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  localparam int SETS = 1 << INDEX_WIDTH;
  localparam int AW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LO   = OFFSET_WIDTH + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_WB     = 2'd2;
  localparam logic [1:0] S_REFILL = 2'd3;

  logic [TAG_WIDTH-1:0]  tag_mem  [SETS][WAYS];
  logic [BLOCK_BITS-1:0] data_mem [SETS][WAYS];
  logic [AW-1:0]         age_mem  [SETS][WAYS];
  logic [WAYS-1:0]       valid_mem [SETS];
  logic [WAYS-1:0]       dirty_mem [SETS];

  logic [1:0]  state;
  logic [31:2] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        first;
  logic [AW-1:0] victim;

  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  req_idx;
  logic [OFFSET_WIDTH-1:0] req_word;
  logic [LO+2:0]           bit_base;
  logic [31:0]             refill_addr;

  logic                  hit;
  logic [AW-1:0]         hit_way;
  logic                  inv_found;
  logic [AW-1:0]         vict;
  logic [BLOCK_BITS-1:0] hit_blk;
  logic [BLOCK_BITS-1:0] new_blk;
  logic [31:0]           hit_word;
  logic [31:0]           merged;
  logic                  lookup_hit;
  logic                  refill_done;
  logic                  unused_bits;

  assign unused_bits = ^cpu_addr[1:0];

  assign req_tag     = req_addr[31 -: TAG_WIDTH];
  assign req_idx     = req_addr[LO +: INDEX_WIDTH];
  assign req_word    = req_addr[2 +: OFFSET_WIDTH];
  assign bit_base    = {req_word, 5'b0};
  assign refill_addr = {req_tag, req_idx, {LO{1'b0}}};

  assign lookup_hit  = (state == S_LOOKUP) && hit;
  assign refill_done = (state == S_REFILL) && mem_req && mem_ack;

  // Tag compare and victim choice for the latched request.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    vict      = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_mem[req_idx][w] &&
          tag_mem[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_mem[req_idx][w]) begin
        inv_found = 1'b1;
        vict      = AW'(w);
      end
    end
    // All ways valid: evict the oldest one.
    if (!inv_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_mem[req_idx][w] == AW'(WAYS - 1))
          vict = AW'(w);
      end
    end
  end

  always_comb begin
    hit_blk  = data_mem[req_idx][hit_way];
    hit_word = hit_blk[bit_base +: 32];
    merged   = hit_word;
    for (int b = 0; b < 4; b++) begin
      if (req_be[b])
        merged[b*8 +: 8] = req_wdata[b*8 +: 8];
    end
    new_blk = hit_blk;
    new_blk[bit_base +: 32] = merged;
  end

  // Valid, dirty and LRU state: reset to a known state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++)
          age_mem[s][w] <= AW'(w);
      end
    end else begin
      if (lookup_hit) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AW'(w) == hit_way)
            age_mem[req_idx][w] <= '0;
          else if (age_mem[req_idx][w] <
                   age_mem[req_idx][hit_way])
            age_mem[req_idx][w] <= age_mem[req_idx][w] + 1'b1;
        end
        if (req_we)
          dirty_mem[req_idx][hit_way] <= 1'b1;
      end
      if (refill_done) begin
        valid_mem[req_idx][victim] <= 1'b1;
        dirty_mem[req_idx][victim] <= 1'b0;
      end
    end
  end

  // Tag and data arrays keep their contents across reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (lookup_hit && req_we)
        data_mem[req_idx][hit_way] <= new_blk;
      if (refill_done) begin
        data_mem[req_idx][victim] <= mem_rdata;
        tag_mem[req_idx][victim]  <= req_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_be    <= '0;
      req_wdata <= '0;
      first     <= 1'b0;
      victim    <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cpu_req && !cpu_ready) begin
            req_addr  <= cpu_addr[31:2];
            req_we    <= cpu_we;
            req_be    <= cpu_byte_en;
            req_wdata <= cpu_wdata;
            first     <= 1'b1;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            cpu_ready <= 1'b1;
            if (!req_we)
              cpu_rdata <= hit_word;
            if (first)
              hit_cnt <= hit_cnt + 32'd1;
            first <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (first)
              miss_cnt <= miss_cnt + 32'd1;
            first   <= 1'b0;
            victim  <= vict;
            mem_req <= 1'b1;
            if (valid_mem[req_idx][vict] &&
                dirty_mem[req_idx][vict]) begin
              mem_we    <= 1'b1;
              mem_addr  <= {tag_mem[req_idx][vict], req_idx,
                            {LO{1'b0}}};
              mem_wdata <= data_mem[req_idx][vict];
              state     <= S_WB;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= refill_addr;
              state    <= S_REFILL;
            end
          end
        end
        S_WB: begin
          if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_REFILL;
          end
        end
        S_REFILL: begin
          // After a writeback, mem_req idles one cycle before refill.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= refill_addr;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_LOOKUP;
          end
        end
      endcase
    end
  end

endmodule
